// File: rtl/arb_resp_router.sv
// Routes in-order downstream responses back to the master that held the grant at address accept.
// Latency: 0 cycles (combinational), or 1 cycle with ARB_RESP_ROUTER_REG_OUT_EN defined.
// Backpressure: req_ready drops when DEPTH transactions are outstanding; responses are never stalled.
module arb_resp_router #(
    parameter int N_MASTERS = 2,
    parameter int W_DATA    = 32,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_MASTERS-1:0]     gnt,
    input  logic                     req_fire,
    output logic                     req_ready,
    input  logic                     rsp_valid,
    input  logic [W_DATA-1:0]        rsp_rdata,
    input  logic                     rsp_err,
    output logic [N_MASTERS-1:0]     m_rsp_valid,
    output logic [W_DATA-1:0]        m_rsp_rdata,
    output logic [N_MASTERS-1:0]     m_rsp_err,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic [1:0]               err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [N_MASTERS-1:0] fifo_mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;

    logic                 gnt_onehot;
    logic                 push;
    logic                 pop;
    logic [N_MASTERS-1:0] head;
    logic [N_MASTERS-1:0] vld_c;
    logic [N_MASTERS-1:0] err_c;

    assign gnt_onehot  = (gnt != '0) && ((gnt & (gnt - N_MASTERS'(1))) == '0);
    // Depends only on the count register, so a same-cycle pop cannot reopen a full FIFO.
    assign req_ready   = (count != CW'(DEPTH));
    assign push        = req_fire && req_ready && gnt_onehot;
    assign pop         = rsp_valid && (count != '0);
    assign head        = fifo_mem[rd_ptr];
    assign vld_c       = pop ? head : '0;
    assign err_c       = (pop && rsp_err) ? head : '0;
    assign outstanding = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 2'b00;
        end else begin
            if (rsp_valid && (count == '0)) begin
                err_sticky[0] <= 1'b1;
            end
            if (req_fire && !gnt_onehot) begin
                err_sticky[1] <= 1'b1;
            end
        end
    end

`ifdef ARB_RESP_ROUTER_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            m_rsp_valid <= '0;
            m_rsp_err   <= '0;
            m_rsp_rdata <= '0;
        end else begin
            m_rsp_valid <= vld_c;
            m_rsp_err   <= err_c;
            m_rsp_rdata <= rsp_rdata;
        end
    end
`else
    assign m_rsp_valid = vld_c;
    assign m_rsp_err   = err_c;
    assign m_rsp_rdata = rsp_rdata;
`endif

endmodule

// File: tb/tb_arb_resp_router.sv
// Randomized and directed bench for arb_resp_router (N_MASTERS=2, W_DATA=32, DEPTH=4).
// Reference model: a queue of grants plus sticky error flags.
module tb_arb_resp_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  gnt;
    logic        req_fire;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    logic [1:0]  m_rsp_err;
    logic [2:0]  outstanding;
    logic [1:0]  err_sticky;

    int checks   = 0;
    int failures = 0;

    logic [1:0]  q[$];
    logic [1:0]  exp_sticky;
    logic [1:0]  exp_vld;
    logic [1:0]  exp_err;
    logic [31:0] exp_data;
    logic [1:0]  s_vld;
    logic [1:0]  s_err;
    logic [31:0] s_data;

    arb_resp_router #(.N_MASTERS(2), .W_DATA(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .req_fire(req_fire), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; updates the model and captures the response outputs for this cycle.
    task automatic drive(input logic r, input logic [1:0] g, input logic f,
                         input logic rv, input logic [31:0] d, input logic e);
        logic ready_ok;
        logic pop_ok;
        rst = r; gnt = g; req_fire = f; rsp_valid = rv; rsp_rdata = d; rsp_err = e;
        if (r) begin
            q.delete();
            exp_sticky = 2'b00; exp_vld = 2'b00; exp_err = 2'b00; exp_data = 32'h0;
        end else begin
            ready_ok = (q.size() < 4);
            pop_ok   = rv && (q.size() != 0);
            exp_vld  = pop_ok ? q[0] : 2'b00;
            exp_err  = (pop_ok && e) ? q[0] : 2'b00;
            exp_data = d;
            if (rv && q.size() == 0) exp_sticky[0] = 1'b1;
            if (f && $countones(g) != 1) exp_sticky[1] = 1'b1;
            if (pop_ok) void'(q.pop_front());
            if (f && ready_ok && $countones(g) == 1) q.push_back(g);
        end
`ifdef ARB_RESP_ROUTER_REG_OUT_EN
        @(posedge clk); #1;
        s_vld = m_rsp_valid; s_err = m_rsp_err; s_data = m_rsp_rdata;
`else
        @(negedge clk);
        s_vld = m_rsp_valid; s_err = m_rsp_err; s_data = m_rsp_rdata;
        @(posedge clk); #1;
`endif
        rst = 1'b0; gnt = 2'b00; req_fire = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_err = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic push(input logic [1:0] g);
        drive(1'b0, g, 1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        idle();
        checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        checks++; if (err_sticky !== 2'b00) begin failures++; $display("FAIL reset_sticky got=%b exp=00", err_sticky); end
        checks++; if (s_vld !== 2'b00) begin failures++; $display("FAIL reset_vld got=%b exp=00", s_vld); end
        checks++; if (s_err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", s_err); end
        checks++; if (s_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", s_data); end
    endtask

    task automatic test_single();
        logic [1:0] gl [2];
        gl[0] = 2'b01; gl[1] = 2'b10;
        for (int i = 0; i < 2; i++) begin
            push(gl[i]);
            checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL single_push_outstanding[%0d] got=%0d exp=1", i, outstanding); end
            drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
            checks++; if (s_vld !== gl[i]) begin failures++; $display("FAIL single_vld[%0d] got=%b exp=%b", i, s_vld, gl[i]); end
            checks++; if (s_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_data[%0d] got=%h exp=deadbeef", i, s_data); end
            checks++; if (s_err !== 2'b00) begin failures++; $display("FAIL single_err[%0d] got=%b exp=00", i, s_err); end
            checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL single_pop_outstanding[%0d] got=%0d exp=0", i, outstanding); end
        end
    endtask

    task automatic test_ordering();
        logic [1:0] ord [4];
        logic [1:0] ev  [4];
        ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b10; ord[3] = 2'b01;
        ev[0] = 2'b00;  ev[1] = 2'b00;  ev[2] = 2'b10;  ev[3] = 2'b00;
        for (int i = 0; i < 4; i++) push(ord[i]);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h1000 + i, (i == 2));
            checks++; if (s_vld !== ord[i]) begin failures++; $display("FAIL order_vld[%0d] got=%b exp=%b", i, s_vld, ord[i]); end
            checks++; if (s_err !== ev[i]) begin failures++; $display("FAIL order_err[%0d] got=%b exp=%b", i, s_err, ev[i]); end
        end
    endtask

    task automatic test_full();
        push(2'b10); push(2'b01); push(2'b01); push(2'b10);
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", req_ready); end
        checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_outstanding got=%0d exp=4", outstanding); end
        push(2'b01);
        checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL full_fifth_ignored got=%0d exp=4", outstanding); end
        // Pop at full: the concurrent fire is refused because ready is low this cycle.
        drive(1'b0, 2'b01, 1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
        checks++; if (s_vld !== 2'b10) begin failures++; $display("FAIL full_pop_vld got=%b exp=10", s_vld); end
        checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL full_pop_outstanding got=%0d exp=3", outstanding); end
        drive(1'b0, 2'b10, 1'b1, 1'b1, 32'hA5A5_0002, 1'b0);
        checks++; if (s_vld !== 2'b01) begin failures++; $display("FAIL pushpop_vld got=%b exp=01", s_vld); end
        checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL pushpop_outstanding got=%0d exp=3", outstanding); end
        push(2'b01);
        checks++; if (outstanding !== 3'd4) begin failures++; $display("FAIL refill_outstanding got=%0d exp=4", outstanding); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hB000 + i, 1'b0);
            checks++; if (s_vld !== exp_vld) begin failures++; $display("FAIL wrap_vld[%0d] got=%b exp=%b", i, s_vld, exp_vld); end
        end
        checks++; if (outstanding !== 3'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL wrap_drained got=%0d/%b exp=0/1", outstanding, req_ready); end
    endtask

    task automatic test_unexpected();
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h1234_5678, 1'b1);
        checks++; if (s_vld !== 2'b00 || s_err !== 2'b00) begin failures++; $display("FAIL unexp_vld got=%b/%b exp=00/00", s_vld, s_err); end
        checks++; if (err_sticky !== 2'b01) begin failures++; $display("FAIL unexp_sticky got=%b exp=01", err_sticky); end
        // A push in the same cycle must not qualify a response at empty.
        drive(1'b0, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0);
        checks++; if (s_vld !== 2'b00) begin failures++; $display("FAIL unexp_samecycle_vld got=%b exp=00", s_vld); end
        checks++; if (outstanding !== 3'd1) begin failures++; $display("FAIL unexp_samecycle_push got=%0d exp=1", outstanding); end
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0);
        checks++; if (s_vld !== 2'b10) begin failures++; $display("FAIL unexp_drain_vld got=%b exp=10", s_vld); end
        idle(); idle();
        checks++; if (err_sticky !== 2'b01) begin failures++; $display("FAIL unexp_sticky_hold got=%b exp=01", err_sticky); end
    endtask

    task automatic test_bad_grant();
        push(2'b11);
        checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL badgnt_11_outstanding got=%0d exp=0", outstanding); end
        checks++; if (err_sticky[1] !== 1'b1) begin failures++; $display("FAIL badgnt_11_sticky got=%b exp=1", err_sticky[1]); end
        push(2'b00);
        checks++; if (outstanding !== 3'd0) begin failures++; $display("FAIL badgnt_00_outstanding got=%0d exp=0", outstanding); end
        checks++; if (err_sticky !== exp_sticky) begin failures++; $display("FAIL badgnt_sticky got=%b exp=%b", err_sticky, exp_sticky); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        push(2'b01); push(2'b10); push(2'b01);
        checks++; if (outstanding !== 3'd3) begin failures++; $display("FAIL mid_pre_outstanding got=%0d exp=3", outstanding); end
        drive(1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0);
        checks++; if (outstanding !== 3'd0 || req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_state got=%0d/%b exp=0/1", outstanding, req_ready); end
        idle();
        checks++; if (s_vld !== 2'b00 || s_err !== 2'b00 || s_data !== 32'h0 || err_sticky !== 2'b00) begin
            failures++; $display("FAIL mid_reset_outputs got=%b/%b/%h/%b exp=0", s_vld, s_err, s_data, err_sticky);
        end
        drive(1'b0, 2'b00, 1'b0, 1'b1, 32'hCAFE_0000, 1'b0);
        checks++; if (s_vld !== 2'b00 || err_sticky !== 2'b01) begin failures++; $display("FAIL mid_stale_rsp got=%b/%b exp=00/01", s_vld, err_sticky); end
    endtask

    task automatic test_random();
        logic [1:0]  g;
        logic        f;
        logic        rv;
        logic        e;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) g = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            else                            g = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            f  = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 1) != 0);
            e  = ($urandom_range(0, 3) == 0);
            d  = $urandom;
            drive(1'b0, g, f, rv, d, e);
            checks++; if (s_vld !== exp_vld || s_err !== exp_err || s_data !== exp_data) begin
                failures++; $display("FAIL rand_rsp[%0d] got=%b/%b/%h exp=%b/%b/%h", i, s_vld, s_err, s_data, exp_vld, exp_err, exp_data);
            end
            checks++; if (outstanding !== 3'(q.size()) || req_ready !== (q.size() < 4)) begin
                failures++; $display("FAIL rand_occ[%0d] got=%0d/%b exp=%0d/%b", i, outstanding, req_ready, q.size(), (q.size() < 4));
            end
            checks++; if (err_sticky !== exp_sticky) begin failures++; $display("FAIL rand_sticky[%0d] got=%b exp=%b", i, err_sticky, exp_sticky); end
        end
    endtask

    initial begin
        rst = 1'b1; gnt = 2'b00; req_fire = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0; rsp_err = 1'b0;
        exp_sticky = 2'b00;
        test_reset();
        test_single();
        test_ordering();
        test_full();
        test_unexpected();
        test_bad_grant();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
